// File: rtl/traffic_light_sequencer_pkg.sv
// Shared mode/lamp codes and the sequencer state encoding.
// State codes are visible on the phase port, so they are pinned explicitly.
package traffic_pkg;

    localparam logic [1:0] MODE_DAY   = 2'b00;
    localparam logic [1:0] MODE_NIGHT = 2'b01;
    localparam logic [1:0] MODE_PED   = 2'b10;
    localparam logic [1:0] MODE_EMG   = 2'b11;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef enum logic [3:0] {
        NS_G     = 4'd0,
        NS_Y     = 4'd1,
        RED_A    = 4'd2,
        EW_G     = 4'd3,
        EW_Y     = 4'd4,
        RED_B    = 4'd5,
        WALK     = 4'd6,
        EMG_HOLD = 4'd7,
        NIGHT    = 4'd8
    } trafficStateT;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dirT;

endpackage

// File: rtl/traffic_light_sequencer_timer.sv
// Down-counting phase timer: load N-1 on state entry, done when it reaches zero.
// It has no reset of its own; the owner forces a load while its reset is high.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Saturates at zero so a state that ignores expiry can never wrap the count.
    always_ff @(posedge clk) begin
        if (load) begin
            count <= loadVal;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/traffic_light_sequencer.sv
// Intersection lamp sequencer: timed day cycle, night flash, pedestrian walk, emergency all-red.
// Lamp and phase outputs are registered from the state, so they trail it by one cycle.
module traffic_light_sequencer
    import traffic_pkg::*;
#(
    parameter int GREEN_CYC = 20,
    parameter int YEL_CYC   = 4,
    parameter int RED_CYC   = 2,
    parameter int WALK_CYC  = 10,
    parameter int FLASH_CYC = 5,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] trafficMode,
    output logic [2:0] nsLight,
    output logic [2:0] ewLight,
    output logic       walk,
    output logic [3:0] phase
);

    localparam logic [CNT_W-1:0] GREEN_LD = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YEL_LD   = CNT_W'(YEL_CYC - 1);
    localparam logic [CNT_W-1:0] RED_LD   = CNT_W'(RED_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_LD  = CNT_W'(WALK_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_CYC - 1);

    trafficStateT     state, stateNext;
    dirT              nextDir, nextDirNext;
    logic             pedPend, pedPendNext;
    logic             flash, flashNext;
    logic             reload;
    logic [CNT_W-1:0] reloadVal;
    logic             timerLoad;
    logic [CNT_W-1:0] timerLoadVal;
    logic             timerEn;
    logic             timerDone;
    logic             isEmg, isPed, isNight, pedReq;
    trafficStateT     greenGo;
    logic [2:0]       nsDec, ewDec;
    logic             walkDec;

    assign isEmg   = (trafficMode == MODE_EMG);
    assign isPed   = (trafficMode == MODE_PED);
    assign isNight = (trafficMode == MODE_NIGHT);
    // A request arriving this cycle acts immediately, not only once latched.
    assign pedReq  = pedPend || isPed;
    assign greenGo = (nextDir == DIR_NS) ? NS_G : EW_G;

    assign timerLoad    = rst || reload;
    assign timerLoadVal = rst ? RED_LD : reloadVal;
    assign timerEn      = (state != EMG_HOLD);

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk    (clk),
        .load   (timerLoad),
        .loadVal(timerLoadVal),
        .en     (timerEn),
        .done   (timerDone)
    );

    always_comb begin
        stateNext   = state;
        nextDirNext = nextDir;
        pedPendNext = pedPend || isPed;
        flashNext   = flash;
        reload      = 1'b0;
        reloadVal   = '0;

        case (state)
            NS_G: if (pedReq || isEmg || timerDone) stateNext = NS_Y;
            EW_G: if (pedReq || isEmg || timerDone) stateNext = EW_Y;
            NS_Y: if (timerDone) begin
                stateNext   = RED_A;
                nextDirNext = DIR_EW;
            end
            EW_Y: if (timerDone) begin
                stateNext   = RED_B;
                nextDirNext = DIR_NS;
            end
            RED_A, RED_B: if (timerDone) begin
                if (isEmg)        stateNext = EMG_HOLD;
                else if (pedReq)  stateNext = WALK;
                else if (isNight) stateNext = NIGHT;
                else              stateNext = greenGo;
            end
            WALK: begin
                if (isEmg)          stateNext = EMG_HOLD;
                else if (timerDone) stateNext = RED_B;
            end
            EMG_HOLD: if (!isEmg) stateNext = RED_B;
            NIGHT: begin
                if (isEmg) begin
                    stateNext = EMG_HOLD;
                end else if (!isNight) begin
                    stateNext = RED_B;
                end else if (timerDone) begin
                    flashNext = !flash;
                    reload    = 1'b1;
                    reloadVal = FLASH_LD;
                end
            end
            default: stateNext = RED_B;
        endcase

        // Entry actions: restart the timer and fix up the bookkeeping flags.
        if (stateNext != state) begin
            reload    = 1'b1;
            flashNext = (stateNext == NIGHT);
            case (stateNext)
                NS_G, EW_G:   reloadVal = GREEN_LD;
                NS_Y, EW_Y:   reloadVal = YEL_LD;
                RED_A, RED_B: reloadVal = RED_LD;
                WALK:         reloadVal = WALK_LD;
                NIGHT:        reloadVal = FLASH_LD;
                default:      reloadVal = '0;
            endcase
            if (stateNext == WALK) pedPendNext = 1'b0;
            if ((stateNext == EMG_HOLD) || (stateNext == NIGHT)) nextDirNext = DIR_NS;
        end
    end

    always_comb begin
        nsDec   = LAMP_R;
        ewDec   = LAMP_R;
        walkDec = 1'b0;
        case (state)
            NS_G:  nsDec = LAMP_G;
            NS_Y:  nsDec = LAMP_Y;
            EW_G:  ewDec = LAMP_G;
            EW_Y:  ewDec = LAMP_Y;
            WALK:  walkDec = 1'b1;
            NIGHT: begin
                nsDec = flash ? LAMP_Y : LAMP_OFF;
                ewDec = flash ? LAMP_R : LAMP_OFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RED_B;
            nextDir <= DIR_NS;
            pedPend <= 1'b0;
            flash   <= 1'b0;
            nsLight <= LAMP_R;
            ewLight <= LAMP_R;
            walk    <= 1'b0;
            phase   <= RED_B;
        end else begin
            state   <= stateNext;
            nextDir <= nextDirNext;
            pedPend <= pedPendNext;
            flash   <= flashNext;
            nsLight <= nsDec;
            ewLight <= ewDec;
            walk    <= walkDec;
            phase   <= state;
        end
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer with short phase lengths and a per-cycle safety monitor.
module tb_traffic_light_sequencer;

    localparam logic [1:0] M_DAY = 2'd0, M_NIGHT = 2'd1, M_PED = 2'd2, M_EMG = 2'd3;
    localparam logic [3:0] P_NSG = 4'd0, P_NSY = 4'd1, P_REDA = 4'd2, P_EWG = 4'd3,
                           P_EWY = 4'd4, P_REDB = 4'd5, P_WALK = 4'd6, P_EMG = 4'd7,
                           P_NIGHT = 4'd8;
    localparam logic [2:0] L_R = 3'b100, L_Y = 3'b010, L_G = 3'b001, L_OFF = 3'b000;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] trafficMode;
    logic [2:0] nsLight, ewLight;
    logic       walk;
    logic [3:0] phase;

    int checkCount = 0;
    int passCount  = 0;
    int cycleNo    = 0;
    logic [2:0] prevNs = 3'b100;
    logic [2:0] prevEw = 3'b100;

    traffic_light_sequencer #(
        .GREEN_CYC(4), .YEL_CYC(2), .RED_CYC(1), .WALK_CYC(3), .FLASH_CYC(2), .CNT_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trafficMode(trafficMode),
        .nsLight    (nsLight),
        .ewLight    (ewLight),
        .walk       (walk),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCount++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycleNo);
        else
            passCount++;
    endtask

    // Expected {ns, ew, walk} for every non-night phase.
    function automatic logic [6:0] expLamps(input logic [3:0] ph);
        case (ph)
            P_NSG:   return {L_G, L_R, 1'b0};
            P_NSY:   return {L_Y, L_R, 1'b0};
            P_EWG:   return {L_R, L_G, 1'b0};
            P_EWY:   return {L_R, L_Y, 1'b0};
            P_WALK:  return {L_R, L_R, 1'b1};
            default: return {L_R, L_R, 1'b0};
        endcase
    endfunction

    task automatic run(input logic r, input logic [1:0] m, input logic [3:0] ph,
                       input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            rst = r;
            trafficMode = m;
            @(posedge clk);
            #2;
            cycleNo++;
            $display("cyc %0d rst=%0b mode=%0d phase=%0d ns=%b ew=%b walk=%b",
                     cycleNo, r, m, phase, nsLight, ewLight, walk);
            checkVal({tag, "_phase"}, {4'b0, phase}, {4'b0, ph});
            if (ph != P_NIGHT)
                checkVal({tag, "_lamps"}, {1'b0, nsLight, ewLight, walk}, {1'b0, expLamps(ph)});
        end
    endtask

    task automatic nightRun(input logic lit, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            run(1'b0, M_NIGHT, P_NIGHT, 1, tag);
            checkVal({tag, "_lamps"}, {1'b0, nsLight, ewLight, walk},
                     lit ? {1'b0, L_Y, L_R, 1'b0} : 8'h00);
        end
    endtask

    // Safety monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            checkVal("inv_rst", {1'b0, nsLight, ewLight, walk}, {1'b0, L_R, L_R, 1'b0});
        end else begin
            if (phase != P_NIGHT)
                checkVal("inv_one_red", {7'b0, (nsLight == L_R) || (ewLight == L_R)}, 8'd1);
            checkVal("inv_walk", {7'b0, walk && (phase != P_WALK)}, 8'd0);
            checkVal("inv_ns_yel", {7'b0, (prevNs == L_G) && (nsLight != L_G) && (nsLight != L_Y)}, 8'd0);
            checkVal("inv_ew_yel", {7'b0, (prevEw == L_G) && (ewLight != L_G) && (ewLight != L_Y)}, 8'd0);
        end
        prevNs = nsLight;
        prevEw = ewLight;
    end

    initial begin
        rst = 1'b1;
        trafficMode = M_DAY;
        repeat (2) @(posedge clk);
        #2;
        checkVal("reset_phase", {4'b0, phase}, {4'b0, P_REDB});
        checkVal("reset_lamps", {1'b0, nsLight, ewLight, walk}, {1'b0, L_R, L_R, 1'b0});

        // 1: plain day cycle, 14-cycle period
        run(1'b0, M_DAY, P_REDB, 1, "t1");
        run(1'b0, M_DAY, P_NSG,  4, "t1");
        run(1'b0, M_DAY, P_NSY,  2, "t1");
        run(1'b0, M_DAY, P_REDA, 1, "t1");
        run(1'b0, M_DAY, P_EWG,  4, "t1");
        run(1'b0, M_DAY, P_EWY,  2, "t1");
        run(1'b0, M_DAY, P_REDB, 1, "t1");
        run(1'b0, M_DAY, P_NSG,  1, "t1");

        // 2: one-cycle ped pulse in NS green cuts it, walk follows, then EW green
        run(1'b0, M_PED, P_NSG,  1, "t2");
        run(1'b0, M_DAY, P_NSY,  2, "t2");
        run(1'b0, M_DAY, P_REDA, 1, "t2");
        run(1'b0, M_DAY, P_WALK, 3, "t2");
        run(1'b0, M_DAY, P_REDB, 1, "t2");
        run(1'b0, M_DAY, P_EWG,  1, "t2");

        // 3: emergency during EW green
        run(1'b0, M_EMG, P_EWG,  1, "t3");
        run(1'b0, M_EMG, P_EWY,  2, "t3");
        run(1'b0, M_EMG, P_REDB, 1, "t3");
        run(1'b0, M_EMG, P_EMG,  3, "t3");
        run(1'b0, M_DAY, P_EMG,  1, "t3");
        run(1'b0, M_DAY, P_REDB, 1, "t3");
        run(1'b0, M_DAY, P_NSG,  1, "t3");

        // 4: night entered at the next all-red expiry, flashing every 2 cycles
        run(1'b0, M_NIGHT, P_NSG,  3, "t4");
        run(1'b0, M_NIGHT, P_NSY,  2, "t4");
        run(1'b0, M_NIGHT, P_REDA, 1, "t4");
        nightRun(1'b1, 2, "t4_lit");
        nightRun(1'b0, 2, "t4_dark");
        nightRun(1'b1, 2, "t4_lit");
        run(1'b0, M_DAY, P_NIGHT, 1, "t4_exit");
        checkVal("t4_exit_lamps", {1'b0, nsLight, ewLight, walk}, 8'h00);
        run(1'b0, M_DAY, P_REDB, 1, "t4");
        run(1'b0, M_DAY, P_NSG,  1, "t4");

        // 5: emergency in the first walk cycle; the serviced request is not repeated
        run(1'b0, M_PED, P_NSG,  1, "t5");
        run(1'b0, M_DAY, P_NSY,  2, "t5");
        run(1'b0, M_DAY, P_REDA, 1, "t5");
        run(1'b0, M_EMG, P_WALK, 1, "t5");
        run(1'b0, M_EMG, P_EMG,  2, "t5");
        run(1'b0, M_DAY, P_EMG,  1, "t5");
        run(1'b0, M_DAY, P_REDB, 1, "t5");
        run(1'b0, M_DAY, P_NSG,  1, "t5");

        // 6: reset during EW yellow restarts the sequence
        run(1'b0, M_DAY, P_NSG,  3, "t6");
        run(1'b0, M_DAY, P_NSY,  2, "t6");
        run(1'b0, M_DAY, P_REDA, 1, "t6");
        run(1'b0, M_DAY, P_EWG,  4, "t6");
        run(1'b0, M_DAY, P_EWY,  1, "t6");
        run(1'b1, M_DAY, P_REDB, 1, "t6_rst");
        run(1'b0, M_DAY, P_REDB, 1, "t6");
        run(1'b0, M_DAY, P_NSG,  4, "t6");
        run(1'b0, M_DAY, P_NSY,  1, "t6");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
